// File: rtl/turn_timer.sv
// Purpose: single-turn countdown timer with pause, restart and abort, counting whole seconds.
// Latency: every output is registered or decoded from state; tick/time_out appear the cycle after the wrap.
// Backpressure: none; start, stop and pause are sampled on every rising edge. stop beats start, start beats pause.
module turn_timer #(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int TURN_SECONDS = 10,
  parameter int SEC_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [SEC_W-1:0] seconds_left,
  output logic             running,
  output logic             tick,
  output logic             time_out,
  output logic             expired
);

  // One prescaler count per clock.
  // Sized so that the count CLK_FREQ_HZ-1 is reachable.
  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_FREQ_HZ - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(TURN_SECONDS);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [SEC_W-1:0] sec;
  logic [SEC_W-1:0] sec_nxt;
  logic             tick_nxt;
  logic             time_out_nxt;
  logic             wrap;

  // The last prescaler count of a second. It only has an effect when the cycle is actually counted.
  assign wrap = (presc == PRE_LAST);

  // Next-state logic. stop overrides start, and start overrides pause and any second boundary.
  // A cycle counts whenever the turn is live (RUNNING or PAUSED) and pause is low.
  // Because of this, the cycle that leaves PAUSED is itself counted, and no cycle is lost on resume.
  always_comb begin
    state_nxt    = state;
    presc_nxt    = presc;
    sec_nxt      = sec;
    tick_nxt     = 1'b0;
    time_out_nxt = 1'b0;
    if (stop) begin
      state_nxt = S_IDLE;
      presc_nxt = '0;
      sec_nxt   = '0;
    end else if (start) begin
      state_nxt = S_RUNNING;
      presc_nxt = '0;
      sec_nxt   = SEC_LOAD;
    end else begin
      case (state)
        S_RUNNING, S_PAUSED: begin
          if (pause) begin
            // Freeze. A pending wrap is deferred, not lost.
            state_nxt = S_PAUSED;
          end else begin
            state_nxt = S_RUNNING;
            if (wrap) begin
              presc_nxt = '0;
              tick_nxt  = 1'b1;
              // The <= also covers a zero count, so seconds_left can never wrap below 0.
              if (sec <= SEC_ONE) begin
                sec_nxt      = '0;
                state_nxt    = S_EXPIRED;
                time_out_nxt = 1'b1;
              end else begin
                sec_nxt = sec - SEC_ONE;
              end
            end else begin
              presc_nxt = presc + PRE_ONE;
            end
          end
        end
        S_EXPIRED: begin
          sec_nxt = '0;
        end
        S_IDLE: begin
          presc_nxt = '0;
          sec_nxt   = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          presc_nxt = '0;
          sec_nxt   = '0;
        end
      endcase
    end
  end

  // State, prescaler and registered pulses. Reset discards any turn in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      presc    <= '0;
      sec      <= '0;
      tick     <= 1'b0;
      time_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      sec      <= sec_nxt;
      tick     <= tick_nxt;
      time_out <= time_out_nxt;
    end
  end

  // The level outputs are decoded from registered state only.
  assign seconds_left = sec;
  assign running      = (state == S_RUNNING);
  assign expired      = (state == S_EXPIRED);

endmodule

// File: tb/tb_turn_timer.sv
// Purpose: scoreboard bench for turn_timer built with CLK_FREQ_HZ=4, TURN_SECONDS=3, SEC_W=4.
// Latency: each expectation is queued on the edge that samples the stimulus and compared on the next falling edge.
// Backpressure: none; the driver advances one clock per step.
module tb_turn_timer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] seconds_left;
  logic       running;
  logic       tick;
  logic       time_out;
  logic       expired;

  typedef struct packed {
    logic [3:0] sec;
    logic       run;
    logic       tk;
    logic       to;
    logic       ex;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  exp_t  e_m;
  string t_m;
  int    n_chk;
  int    n_pass;

  turn_timer #(.CLK_FREQ_HZ(4), .TURN_SECONDS(3), .SEC_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .seconds_left (seconds_left),
    .running      (running),
    .tick         (tick),
    .time_out     (time_out),
    .expired      (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value differs from the expected one.
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic exp_t mk(input int sec, input bit run, input bit tk, input bit to, input bit ex);
    exp_t r;
    r.sec = 4'(sec);
    r.run = run;
    r.tk  = tk;
    r.to  = to;
    r.ex  = ex;
    return r;
  endfunction

  // Expected outputs after c counted cycles of a 3-second turn of 4-cycle seconds, with p as the pause level.
  function automatic exp_t turn_exp(input int c, input bit p);
    return mk((c < 12) ? 3 - c / 4 : 0, !p && (c < 12), (c != 0) && (c % 4 == 0) && (c <= 12), c == 12, c >= 12);
  endfunction

  function automatic exp_t idle_exp();
    return mk(0, 0, 0, 0, 0);
  endfunction

  task automatic step(input logic s, input logic sp, input logic p, input exp_t e, input string tag);
    start = s;
    stop  = sp;
    pause = p;
    @(posedge clk);
    sb.push_back(e);
    tq.push_back(tag);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sec"},  int'(seconds_left), 0);
    check({tag, ".run"},  int'(running),      0);
    check({tag, ".tick"}, int'(tick),         0);
    check({tag, ".to"},   int'(time_out),     0);
    check({tag, ".ex"},   int'(expired),      0);
  endtask

  // Scoreboard: compare the oldest pending expectation on each falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e_m = sb.pop_front();
      t_m = tq.pop_front();
      check({t_m, ".sec"},  int'(seconds_left), int'(e_m.sec));
      check({t_m, ".run"},  int'(running),      int'(e_m.run));
      check({t_m, ".tick"}, int'(tick),         int'(e_m.tk));
      check({t_m, ".to"},   int'(time_out),     int'(e_m.to));
      check({t_m, ".ex"},   int'(expired),      int'(e_m.ex));
    end
  end

  initial begin
    int c;
    bit p;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    #1;
    check_all_zero("reset");
    #21;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) step(0, 0, 0, idle_exp(), $sformatf("post_rst k=%0d", k));

    // Basic turn, then hold in EXPIRED, then restart from EXPIRED, then stop.
    for (int k = 0; k < 16; k++) step(k == 0, 0, 0, turn_exp(k, 0), $sformatf("basic k=%0d", k));
    step(1, 0, 0, mk(3, 1, 0, 0, 0), "restart_from_expired");
    step(0, 1, 0, idle_exp(), "stop_after_restart");
    step(0, 0, 0, idle_exp(), "idle_a");

    // Pause held for 10 cycles starting at cycle 2.
    for (int k = 0; k < 25; k++) begin
      p = (k >= 2) && (k <= 11);
      c = (k < 2) ? k : ((k < 12) ? 1 : k - 10);
      step(k == 0, 0, p, turn_exp(c, p), $sformatf("pause k=%0d", k));
    end
    step(0, 1, 0, idle_exp(), "stop_b");

    // Restart at cycle 7.
    for (int k = 0; k < 22; k++) begin
      c = (k < 7) ? k : k - 7;
      step(k == 0 || k == 7, 0, 0, turn_exp(c, 0), $sformatf("restart k=%0d", k));
    end
    step(0, 1, 0, idle_exp(), "stop_c");

    // stop and start together while RUNNING.
    for (int k = 0; k < 5; k++) step(k == 0, 0, 0, turn_exp(k, 0), $sformatf("stopstart k=%0d", k));
    step(1, 1, 0, idle_exp(), "stop_and_start");
    for (int k = 0; k < 3; k++) step(0, 0, 0, idle_exp(), $sformatf("stopstart_idle k=%0d", k));

    // start lands on the final second's terminal cycle.
    for (int k = 0; k < 27; k++) begin
      c = (k < 12) ? k : k - 12;
      step(k == 0 || k == 12, 0, 0, turn_exp(c, 0), $sformatf("start_on_last k=%0d", k));
    end
    step(0, 1, 0, idle_exp(), "stop_e");

    // pause lands on a terminal cycle: no decrement, and the tick is deferred by one cycle.
    for (int k = 0; k < 10; k++) begin
      p = (k == 4);
      c = (k < 4) ? k : k - 1;
      step(k == 0, 0, p, turn_exp(c, p), $sformatf("pause_on_wrap k=%0d", k));
    end
    step(0, 1, 0, idle_exp(), "stop_f");

    // Asynchronous reset in the middle of cycle 5.
    for (int k = 0; k < 5; k++) step(k == 0, 0, 0, turn_exp(k, 0), $sformatf("arst k=%0d", k));
    start = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("arst_immediate");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) step(0, 0, 0, idle_exp(), $sformatf("arst_release k=%0d", k));

    repeat (3) @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/turn_timer.md
TURN_TIMER -- requirements
Module: turn_timer

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50000000: input clock frequency; one second = CLK_FREQ_HZ cycles; legal range >= 2.
REQ-002 Parameter TURN_SECONDS, default 10: turn duration in whole seconds; legal range 1 .. 2^SEC_W-1.
REQ-003 Parameter SEC_W, default 4: width of the seconds_left output.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 start  input  1  load TURN_SECONDS and begin counting; honoured in every state.
REQ-007 stop  input  1  abandon the turn and return to IDLE.
REQ-008 pause  input  1  level; while 1 in RUNNING, counting freezes.
REQ-009 seconds_left  output  SEC_W  whole seconds remaining in the current turn.
REQ-010 running  output  1  1 while in RUNNING.
REQ-011 tick  output  1  one-cycle pulse on each completed second of counting.
REQ-012 time_out  output  1  one-cycle pulse when the turn expires.
REQ-013 expired  output  1  level; 1 while in EXPIRED.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUNNING, PAUSED, EXPIRED.
REQ-015 Input priority SHALL be stop > start > pause.
REQ-016 stop=1 in any state -> next state IDLE, prescaler=0, seconds_left=0.
REQ-017 start=1 with stop=0 in any state -> next state RUNNING, prescaler=0, seconds_left=TURN_SECONDS.
REQ-018 This includes a restart mid-turn and from PAUSED or EXPIRED.
REQ-019 RUNNING with pause=1 (no stop/start) -> PAUSED; prescaler and seconds_left hold.
REQ-020 PAUSED with pause=0 -> RUNNING; counting resumes from the held prescaler value, no cycle lost or added.
REQ-021 Prescaler width SHALL be clog2(CLK_FREQ_HZ).
REQ-022 In RUNNING without pause, the prescaler SHALL increment each cycle and wrap from CLK_FREQ_HZ-1 to 0.
REQ-023 The wrap cycle SHALL be the terminal cycle; the prescaler is held in all other states.
REQ-024 On a terminal cycle, seconds_left SHALL decrement by 1 and tick SHALL be 1 in the following cycle.
REQ-025 tick is registered, one cycle wide, and 0 outside RUNNING except for that cycle.
REQ-026 A terminal cycle with seconds_left==1 SHALL set seconds_left=0 and move to EXPIRED.
REQ-027 In that case time_out=1 for exactly one cycle, coincident with the first EXPIRED cycle and with tick.
REQ-028 EXPIRED SHALL hold seconds_left=0 and expired=1 until start or stop; time_out SHALL NOT re-pulse.
REQ-029 Turn length from the start-sampling edge to time_out SHALL be exactly TURN_SECONDS*CLK_FREQ_HZ cycles.
REQ-030 seconds_left SHALL never underflow or wrap below 0.
REQ-031 start and a terminal cycle in the same cycle -> start wins; seconds_left=TURN_SECONDS, no tick, no time_out.
REQ-032 pause and a terminal cycle in the same cycle -> pause takes effect first; no decrement, state PAUSED.
REQ-033 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, prescaler=0, seconds_left=0, running=0, tick=0, time_out=0, expired=0.
REQ-035 Reset asserted mid-turn SHALL discard the turn.
REQ-036 After rst returns to 1, the block SHALL stay in IDLE until start.

Verification (CLK_FREQ_HZ=4, TURN_SECONDS=3, SEC_W=4)
REQ-037 Basic turn: start for 1 cycle -> seconds_left 3,2,1,0 at 4-cycle spacing; tick at cycles 4, 8 and 12 after start; time_out=1 only at cycle 12; expired=1 from cycle 12 onward.
REQ-038 Pause: pause=1 for 10 cycles starting at cycle 2 -> time_out at cycle 22; seconds_left frozen at 3 throughout the pause.
REQ-039 Restart: start at cycle 0, second start at cycle 7 -> seconds_left=3 at cycle 8; time_out at cycle 19; no time_out at cycle 12.
REQ-040 Stop vs start: stop=1 and start=1 in the same cycle during RUNNING -> IDLE, seconds_left=0, running=0.
REQ-041 Async reset: rst=0 mid-cycle at cycle 5 -> all outputs 0 immediately, without waiting for a clock edge; no time_out after release without a new start.
REQ-042 Boundary: start in the same cycle as the terminal cycle with seconds_left=1 -> no time_out; seconds_left=3; state RUNNING.
